isr_sequencer: RTL
==================

Name: isr_sequencer

Overview:
- Front-end job sequencer that sits directly upstream of the ISR integer-square-root unit.
- Accepts 64-bit radicands on a valid/ready stream and buffers them in a small FIFO.
- Launches ISR jobs one at a time: presents the value, pulses ISR's active-high reset, then waits for ISR done.
- Returns each 32-bit root, in order, on a valid/ready output stream.

Parameters:
- DEPTH, 4, input FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 128, watchdog limit counted in RUN cycles (used only with ISR_SEQ_TIMEOUT_EN).

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clock.
- in_valid  in  1  input job valid.
- in_ready  out  1  FIFO can accept; equals !full, combinational from count only.
- in_value  in  64  radicand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  floor(sqrt(value)) from ISR.
- out_value  out  64  radicand that produced out_result.
- isr_reset  out  1  drives ISR reset (active-high); registered.
- isr_value  out  64  drives ISR value; registered, stable for the whole job.
- isr_result  in  32  ISR result.
- isr_done  in  1  ISR done.
- out_err  out  1  only with ISR_SEQ_TIMEOUT_EN: result is a timeout, not a root.

Behaviour:
- Reset (reset==0 at posedge): FIFO emptied (ptrs/count 0), state IDLE, isr_reset=1, isr_value=0, out_valid=0, out_result=0, out_value=0, out_err=0. Reset mid-job abandons the job; ISR stays held in reset.
- FIFO:
  - push on in_valid&&in_ready; pop only by FSM in IDLE.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (no combinational pass-through).
  - Jobs are never dropped or reordered.
- FSM states: IDLE, LOAD, RUN, OUT.
  - IDLE: isr_reset=1. If FIFO non-empty at posedge: pop head, isr_value<=head, load_cnt<=0, go to LOAD.
  - LOAD: isr_reset=1 for exactly 2 cycles with isr_value stable, then isr_reset<=0 and go to RUN; run_cnt<=0.
  - RUN: isr_reset=0. On the first posedge with isr_done=1: out_result<=isr_result, out_value<=isr_value, out_valid<=1, isr_reset<=1, go to OUT. isr_done is ignored in every state other than RUN.
  - OUT: hold out_* stable. On out_valid&&out_ready: out_valid<=0, go to IDLE. No new job starts until the result is accepted (single result register).
- Latency: push at edge k into empty FIFO in IDLE → pop at k+1 → LOAD k+1..k+2 → RUN from k+3 → out_valid one edge after isr_done is sampled high.
- isr_value changes only on IDLE→LOAD, so a changing upstream in_value never perturbs a running job.
- Back-to-back jobs: OUT→IDLE→LOAD gives a minimum of 2 reset cycles between ISR jobs.

Optional Feature:
- Macro ISR_SEQ_TIMEOUT_EN.
- Defined:
  - run_cnt increments each RUN cycle.
  - If run_cnt reaches TIMEOUT_CYCLES-1 without isr_done: out_result=32'hFFFF_FFFF, out_err=1, go to OUT.
  - out_err is registered with out_result and cleared on acceptance.
- Not defined: out_err port absent, no counter; RUN waits indefinitely.

Test Plan:
- Smallest: push value 0 → isr_reset high 2 cycles then low; ISR model done → out_result=0, out_value=0 at the expected latency.
- Largest: push 64'hFFFF_FFFE_0000_0001 → out_result=32'hFFFF_FFFF; isr_value constant from LOAD through OUT.
- Fill/backpressure: out_ready=0, push DEPTH+2 values (121, 144, 169, 196, 225, 256) → in_ready drops after DEPTH+1 accepted (one in flight); releasing out_ready yields 11, 12, 13, 14, 15, 16 in order, none lost.
- Upstream change: accept 10000, then drive in_value=10201 with in_valid=0 during RUN → result 100, not 101.
- Reset mid-RUN: start 1,000,000, assert reset (low) 1 cycle during RUN, then push 121 → isr_reset=1 through reset; only out_result=11 appears, out_valid never pulses for the abandoned job.
- ISR_SEQ_TIMEOUT_EN: ISR model never asserts done → out_valid with out_err=1 and out_result=32'hFFFF_FFFF exactly TIMEOUT_CYCLES cycles after entering RUN; next job then completes normally with out_err=0.

Source files
------------

// File: rtl/isr_sequencer.sv
// Job sequencer in front of the ISR integer-square-root unit: FIFO-buffers radicands, runs one ISR job at a time.
// Optional RUN-state watchdog with out_err flag when ISR_SEQ_TIMEOUT_EN is defined.
module isr_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [63:0] out_value,
    output logic        isr_reset,
    output logic [63:0] isr_value,
    input  logic [31:0] isr_result,
    input  logic        isr_done
`ifdef ISR_SEQ_TIMEOUT_EN
    ,
    output logic        out_err
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("isr_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    logic [63:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    state_t        state_reg;
    state_t        state_next;
    logic          load_cnt_reg;
    logic          push;
    logic          pop;
    logic          timeout_hit;

    // Ready depends on occupancy only, so a full FIFO never accepts even while popping.
    assign in_ready = (count_reg != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_reg == IDLE) && (count_reg != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= in_value;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = LOAD;
            LOAD:    if (load_cnt_reg) state_next = RUN;
            RUN:     if (isr_done || timeout_hit) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // isr_value is written only when a job is popped, keeping it stable from LOAD through OUT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            isr_reset    <= 1'b1;
            isr_value    <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_value    <= '0;
            load_cnt_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        isr_value    <= fifo_mem[rd_ptr_reg];
                        load_cnt_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    load_cnt_reg <= 1'b1;
                    if (load_cnt_reg)
                        isr_reset <= 1'b0;
                end
                RUN: begin
                    if (isr_done) begin
                        out_result <= isr_result;
                        out_value  <= isr_value;
                        out_valid  <= 1'b1;
                        isr_reset  <= 1'b1;
                    end else if (timeout_hit) begin
                        out_result <= '1;
                        out_value  <= isr_value;
                        out_valid  <= 1'b1;
                        isr_reset  <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ISR_SEQ_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT_CYCLES - 1);

    logic [RW-1:0] run_cnt_reg;

    assign timeout_hit = (run_cnt_reg == RUN_LAST);

    // A done seen on the final watchdog cycle still wins over the timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            run_cnt_reg <= '0;
            out_err     <= 1'b0;
        end else begin
            if (state_reg == LOAD)
                run_cnt_reg <= '0;
            else if (state_reg == RUN)
                run_cnt_reg <= run_cnt_reg + RW'(1);
            if (state_reg == RUN && !isr_done && timeout_hit)
                out_err <= 1'b1;
            else if (state_reg == OUT && out_ready)
                out_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
